// File: rtl/sdio_rx_buf_if.sv
// SDIO receive buffer bus: sampler/DMA-side controls in,
// buffer contents and status out.
interface sdio_rx_buf_if #(
  parameter int LEN = 16
);
  logic           rx_rst;
  logic           rx_start;
  logic           bus_width;
  logic [LEN-1:0] blk_len;
  logic           dat_vld;
  logic [3:0]     dat_in;
  logic           buf_free;
  logic [7:0]     buf0;
  logic [7:0]     buf1;
  logic           buf0_rd_rdy;
  logic           buf1_rd_rdy;
  logic           rx_hold;
  logic           rx_overflow;
  logic           rx_done;
  logic [LEN-1:0] rx_cnt;
  logic [3:0]     rx_state;

  modport master (
    output rx_rst, rx_start, bus_width, blk_len,
    output dat_vld, dat_in, buf_free,
    input  buf0, buf1, buf0_rd_rdy, buf1_rd_rdy,
    input  rx_hold, rx_overflow, rx_done, rx_cnt, rx_state
  );

  modport slave (
    input  rx_rst, rx_start, bus_width, blk_len,
    input  dat_vld, dat_in, buf_free,
    output buf0, buf1, buf0_rd_rdy, buf1_rd_rdy,
    output rx_hold, rx_overflow, rx_done, rx_cnt, rx_state
  );
endinterface

// File: rtl/sdio_rx_buf.sv
// SDIO slave-write receive path: assembles 1/4-bit samples into bytes
// and hands them to the DMA through a two-entry ping-pong buffer.
module sdio_rx_buf #(
  parameter int LEN = 16
) (
  input logic         bus_clk,
  input logic         rstn,
  sdio_rx_buf_if.slave rx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    DRAIN = 3'd2
  } st_e;

  st_e            st_q, st_d;
  logic           width_q, width_d;
  logic [LEN-1:0] len_q, len_d;
  logic [LEN-1:0] cnt_q, cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     buf0_q, buf0_d;
  logic [7:0]     buf1_q, buf1_d;
  logic [2:0]     bit_q, bit_d;
  logic           wr_q, wr_d;
  logic           rd_q, rd_d;
  logic [1:0]     rdy_q, rdy_d;
  logic           hold_q, hold_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic [2:0]     bit_nxt;
  logic [7:0]     shift_nxt;
  logic           free;
  logic           byte_done;

  always_comb begin
    bit_nxt   = bit_q + (width_q ? 3'd4 : 3'd1);
    shift_nxt = width_q ? {shift_q[3:0], rx.dat_in}
                        : {shift_q[6:0], rx.dat_in[0]};
    free      = rx.buf_free & rdy_q[rd_q] & (st_q != IDLE);
    byte_done = (st_q == RECV) & rx.dat_vld & (bit_nxt == 3'd0);

    st_d    = st_q;
    width_d = width_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    bit_d   = bit_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    rdy_d   = rdy_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    // Release first so a byte landing this cycle can reuse the slot.
    if (free) begin
      rdy_d[rd_q] = 1'b0;
      rd_d        = ~rd_q;
    end

    unique case (st_q)
      IDLE: begin
        bit_d = 3'd0;
        wr_d  = 1'b0;
        rd_d  = 1'b0;
        cnt_d = '0;
        rdy_d = 2'b00;
        if (rx.rx_start) begin
          width_d = rx.bus_width;
          len_d   = rx.blk_len;
          ovf_d   = 1'b0;
          st_d    = RECV;
        end
      end
      RECV: begin
        if (rx.dat_vld) begin
          bit_d   = bit_nxt;
          shift_d = shift_nxt;
        end
        if (byte_done) begin
          cnt_d = cnt_q + 1'b1;
          if (!rdy_d[wr_q]) begin
            if (wr_q) buf1_d = shift_nxt;
            else      buf0_d = shift_nxt;
            rdy_d[wr_q] = 1'b1;
            wr_d        = ~wr_q;
          end else begin
            ovf_d = 1'b1;
          end
          if (cnt_d == len_q) st_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rdy_q == 2'b00) begin
          done_d = 1'b1;
          st_d   = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase

    hold_d = &rdy_d;

    if (rx.rx_rst) begin
      st_d    = IDLE;
      width_d = 1'b0;
      len_d   = '0;
      cnt_d   = '0;
      shift_d = 8'h00;
      buf0_d  = 8'h00;
      buf1_d  = 8'h00;
      bit_d   = 3'd0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      rdy_d   = 2'b00;
      hold_d  = 1'b0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge bus_clk or negedge rstn) begin
    if (!rstn) begin
      st_q    <= IDLE;
      width_q <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      shift_q <= 8'h00;
      buf0_q  <= 8'h00;
      buf1_q  <= 8'h00;
      bit_q   <= 3'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdy_q   <= 2'b00;
      hold_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      width_q <= width_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      bit_q   <= bit_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign rx.buf0        = buf0_q;
  assign rx.buf1        = buf1_q;
  assign rx.buf0_rd_rdy = rdy_q[0];
  assign rx.buf1_rd_rdy = rdy_q[1];
  assign rx.rx_hold     = hold_q;
  assign rx.rx_overflow = ovf_q;
  assign rx.rx_done     = done_q;
  assign rx.rx_cnt      = cnt_q;
  assign rx.rx_state    = {wr_q, st_q};

endmodule

// File: tb/tb_sdio_rx_buf.sv
// Directed and randomized checks of sdio_rx_buf against byte-level
// expectations and a queue scoreboard of DMA reads.
module tb_sdio_rx_buf;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  sdio_rx_buf_if #(.LEN(16)) ifc ();

  sdio_rx_buf #(.LEN(16)) dut (
    .bus_clk (clk),
    .rstn    (rstn),
    .rx      (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [3:0] d,
                     input logic f);
    ifc.dat_vld  = v;
    ifc.dat_in   = d;
    ifc.buf_free = f;
    @(posedge clk);
    #1;
    ifc.dat_vld  = 1'b0;
    ifc.buf_free = 1'b0;
    ifc.rx_start = 1'b0;
    ifc.rx_rst   = 1'b0;
  endtask

  task automatic start(input logic w, input logic [15:0] len);
    ifc.bus_width = w;
    ifc.blk_len   = len;
    ifc.rx_start  = 1'b1;
    cyc(1'b0, 4'h0, 1'b0);
  endtask

  logic [7:0] exp_q[$];
  logic [3:0] smp[$];
  logic [7:0] bv;
  logic [7:0] bits;
  logic       w;
  logic       v;
  logic       f;
  logic       rr;
  logic       rp;
  logic       dn;
  int         len;
  int         si;

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    ifc.rx_rst    = 1'b0;
    ifc.rx_start  = 1'b0;
    ifc.bus_width = 1'b0;
    ifc.blk_len   = '0;
    ifc.dat_vld   = 1'b0;
    ifc.dat_in    = 4'h0;
    ifc.buf_free  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    cyc(1'b0, 4'h0, 1'b0);

    chk("rst_buf0", ifc.buf0, 8'h00);
    chk("rst_buf1", ifc.buf1, 8'h00);
    chk("rst_rdy", {ifc.buf1_rd_rdy, ifc.buf0_rd_rdy}, 2'b00);
    chk("rst_hold", ifc.rx_hold, 1'b0);
    chk("rst_ovf", ifc.rx_overflow, 1'b0);
    chk("rst_done", ifc.rx_done, 1'b0);
    chk("rst_cnt", ifc.rx_cnt, 16'd0);
    chk("rst_state", ifc.rx_state, 4'h0);

    // 4-bit block of two bytes, DMA frees two cycles after ready
    start(1'b1, 16'd2);
    chk("t1_state_recv", ifc.rx_state, 4'h1);
    cyc(1'b1, 4'hA, 1'b0);
    chk("t1_half_rdy", ifc.buf0_rd_rdy, 1'b0);
    cyc(1'b1, 4'h5, 1'b0);
    chk("t1_buf0", ifc.buf0, 8'hA5);
    chk("t1_rdy0", ifc.buf0_rd_rdy, 1'b1);
    chk("t1_state_b1", ifc.rx_state, 4'h9);
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b1, 4'hC, 1'b1);
    chk("t1_buf1", ifc.buf1, 8'h3C);
    chk("t1_rdy", {ifc.buf1_rd_rdy, ifc.buf0_rd_rdy}, 2'b10);
    chk("t1_cnt", ifc.rx_cnt, 16'd2);
    chk("t1_state_drain", ifc.rx_state, 4'h2);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t1_no_early_done", ifc.rx_done, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    chk("t1_rdy1_clr", ifc.buf1_rd_rdy, 1'b0);
    chk("t1_done_wait", ifc.rx_done, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t1_done", ifc.rx_done, 1'b1);
    chk("t1_idle", ifc.rx_state, 4'h0);
    chk("t1_ovf", ifc.rx_overflow, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t1_done_1cyc", ifc.rx_done, 1'b0);

    // 1-bit block of one byte 0x96
    start(1'b0, 16'd1);
    bits = 8'h96;
    for (int j = 7; j >= 0; j--) begin
      if (j == 0) chk("t2_rdy_before", ifc.buf0_rd_rdy, 1'b0);
      cyc(1'b1, {3'b101, bits[j]}, 1'b0);
    end
    chk("t2_buf0", ifc.buf0, 8'h96);
    chk("t2_rdy0", ifc.buf0_rd_rdy, 1'b1);
    chk("t2_state", ifc.rx_state, 4'hA);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t2_done", ifc.rx_done, 1'b1);

    // 4-bit block of three bytes with no DMA service
    start(1'b1, 16'd3);
    cyc(1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h2, 1'b0);
    chk("t3_hold_b1", ifc.rx_hold, 1'b0);
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b1, 4'h4, 1'b0);
    chk("t3_hold", ifc.rx_hold, 1'b1);
    chk("t3_ovf_pre", ifc.rx_overflow, 1'b0);
    cyc(1'b1, 4'h5, 1'b0);
    cyc(1'b1, 4'h6, 1'b0);
    chk("t3_ovf", ifc.rx_overflow, 1'b1);
    chk("t3_buf0", ifc.buf0, 8'h12);
    chk("t3_buf1", ifc.buf1, 8'h34);
    chk("t3_cnt", ifc.rx_cnt, 16'd3);
    chk("t3_state", ifc.rx_state, 4'h2);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t3_done", ifc.rx_done, 1'b1);
    chk("t3_ovf_sticky", ifc.rx_overflow, 1'b1);

    // byte completes into full buf0 while buf0 is freed
    start(1'b1, 16'd3);
    chk("t4_ovf_clr", ifc.rx_overflow, 1'b0);
    cyc(1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h2, 1'b0);
    cyc(1'b1, 4'h2, 1'b0);
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b1, 4'h3, 1'b1);
    chk("t4_buf0", ifc.buf0, 8'h33);
    chk("t4_rdy", {ifc.buf1_rd_rdy, ifc.buf0_rd_rdy}, 2'b11);
    chk("t4_ovf", ifc.rx_overflow, 1'b0);
    chk("t4_state", ifc.rx_state, 4'hA);
    chk("t4_hold", ifc.rx_hold, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    chk("t4_rdy_after", {ifc.buf1_rd_rdy, ifc.buf0_rd_rdy}, 2'b01);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t4_done", ifc.rx_done, 1'b1);

    // abort mid-byte, then a fresh block
    start(1'b1, 16'd2);
    cyc(1'b1, 4'h7, 1'b0);
    cyc(1'b1, 4'h8, 1'b0);
    cyc(1'b1, 4'h9, 1'b0);
    chk("t5_pre_rdy", ifc.buf0_rd_rdy, 1'b1);
    ifc.rx_rst = 1'b1;
    cyc(1'b0, 4'h0, 1'b0);
    chk("t5_state", ifc.rx_state, 4'h0);
    chk("t5_rdy", {ifc.buf1_rd_rdy, ifc.buf0_rd_rdy}, 2'b00);
    chk("t5_cnt", ifc.rx_cnt, 16'd0);
    chk("t5_hold", ifc.rx_hold, 1'b0);
    start(1'b1, 16'd1);
    cyc(1'b1, 4'h4, 1'b0);
    chk("t5_half", ifc.buf0_rd_rdy, 1'b0);
    cyc(1'b1, 4'hB, 1'b0);
    chk("t5_buf0", ifc.buf0, 8'h4B);
    chk("t5_cnt1", ifc.rx_cnt, 16'd1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t5_done", ifc.rx_done, 1'b1);

    // free while empty and rx_start during RECV are ignored
    start(1'b1, 16'd2);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b1, 4'hC, 1'b0);
    cyc(1'b1, 4'h3, 1'b0);
    chk("t6_buf0", ifc.buf0, 8'hC3);
    ifc.rx_start  = 1'b1;
    ifc.bus_width = 1'b0;
    ifc.blk_len   = 16'd1;
    cyc(1'b1, 4'h5, 1'b0);
    chk("t6_state", ifc.rx_state, 4'h9);
    cyc(1'b1, 4'hA, 1'b0);
    chk("t6_buf1", ifc.buf1, 8'h5A);
    chk("t6_cnt", ifc.rx_cnt, 16'd2);
    cyc(1'b0, 4'h0, 1'b1);
    chk("t6_rdptr", {ifc.buf1_rd_rdy, ifc.buf0_rd_rdy}, 2'b10);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t6_done", ifc.rx_done, 1'b1);

    // randomized blocks: DMA reads checked against generated bytes
    for (int b = 0; b < 8; b++) begin
      w   = 1'($urandom % 2);
      len = $urandom_range(1, 12);
      exp_q.delete();
      smp.delete();
      for (int k = 0; k < len; k++) begin
        bv = 8'($urandom);
        exp_q.push_back(bv);
        if (w) begin
          smp.push_back(bv[7:4]);
          smp.push_back(bv[3:0]);
        end else begin
          for (int j = 7; j >= 0; j--)
            smp.push_back({3'($urandom), bv[j]});
        end
      end
      start(w, 16'(len));
      rp = 1'b0;
      si = 0;
      dn = 1'b0;
      for (int c = 0; c < 2000 && !dn; c++) begin
        v  = (si < smp.size()) && !ifc.rx_hold &&
             ($urandom % 4 != 0);
        rr = rp ? ifc.buf1_rd_rdy : ifc.buf0_rd_rdy;
        f  = rr && ($urandom % 2 == 1);
        if (f) begin
          chk("rnd_byte", rp ? ifc.buf1 : ifc.buf0,
              exp_q.pop_front());
          rp = ~rp;
        end
        cyc(v, v ? smp[si] : 4'h0, f);
        if (v) begin
          si++;
          if (si == smp.size())
            chk("rnd_cnt", ifc.rx_cnt, 32'(len));
        end
        if (ifc.rx_done) dn = 1'b1;
      end
      chk("rnd_done", dn, 1'b1);
      chk("rnd_ovf", ifc.rx_overflow, 1'b0);
      chk("rnd_left", exp_q.size(), 32'd0);
      cyc(1'b0, 4'h0, 1'b0);
      chk("rnd_done_1cyc", ifc.rx_done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
